// File: rtl/cpu_run_ctrl.sv
// Run controller for CPU_Core: sequences core reset, watches the IMEM fetch bus for halt/timeout.
// Latency: every output is registered; a state change is visible one cycle after its triggering edge.
// Backpressure: none; start is a pulse and is ignored while CORE_RST, SETTLE or RUN is in progress.
//
// Ports:
//   CLK, RST          clock (rising edge) and synchronous active-high reset
//   start             pulse that begins a run from IDLE, HALTED or TIMED_OUT
//   Instruction       IMEM read data; HALT_WORD stops the run
//   address_IMEM      core fetch address; repeated addresses count towards loop halt
//   MemWrite, address_DMEM, write_data_DMEM   DMEM write bus (tohost detection only)
//   core_RSTn         active-low reset to CPU_Core
//   running/done/timeout                     RUN / HALTED / TIMED_OUT indicators
//   cycle_count, fetch_count                 saturating RUN statistics
//   halt_pc, exit_code                       address at stop, tohost value
//
// Optional feature: define TOHOST_EN to halt on a DMEM write to TOHOST_ADDR and report its data
// on exit_code. Without it the DMEM inputs are ignored and exit_code is tied to zero.

module cpu_run_ctrl #(
    parameter int          ADDR_W     = 10,
    parameter logic [31:0] HALT_WORD  = 32'h0000_0000,
    parameter int          RST_CYCLES = 2,
    parameter int          SETTLE     = 1,
    parameter int          LOOP_N     = 4,
    parameter int          TIMEOUT    = 100000,
    parameter int          CNT_W      = 32
`ifdef TOHOST_EN
    ,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'('h3FC)
`endif
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [31:0]       Instruction,
    input  logic [ADDR_W-1:0] address_IMEM,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] address_DMEM,
    input  logic [31:0]       write_data_DMEM,
    output logic              core_RSTn,
    output logic              running,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  fetch_count,
    output logic [ADDR_W-1:0] halt_pc,
    output logic [31:0]       exit_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CORE_RST,
        S_SETTLE,
        S_RUN,
        S_HALTED,
        S_TIMED_OUT
    } state_t;

    localparam int              LW       = (LOOP_N < 2) ? 1 : $clog2(LOOP_N + 1);
    localparam logic [LW-1:0]   LOOP_LIM = LW'(LOOP_N);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [15:0]     RST_LAST = 16'(RST_CYCLES - 1);
    localparam logic [15:0]     SET_LAST = 16'(SETTLE - 1);

    state_t            state;
    logic [15:0]       phase_cnt;
    logic [ADDR_W-1:0] prev_addr;
    logic [LW-1:0]     loop_cnt;
    logic              first_run;   // prev_addr holds nothing meaningful on the first RUN cycle

    logic              addr_same;
    logic              addr_diff;
    logic [LW-1:0]     loop_nxt;
    logic              loop_hit;
    logic              tohost_hit;
    logic              halt_hit;
    logic              timeout_hit;
    logic [CNT_W-1:0]  cycle_nxt;
    logic [CNT_W-1:0]  fetch_nxt;

`ifdef TOHOST_EN
    assign tohost_hit = MemWrite && (address_DMEM == TOHOST_ADDR);
`else
    logic unused_dmem;
    assign unused_dmem = ^{MemWrite, address_DMEM, write_data_DMEM};
    assign tohost_hit  = 1'b0;
    assign exit_code   = '0;
`endif

    always_comb begin
        addr_same   = !first_run && (address_IMEM == prev_addr);
        addr_diff   = !first_run && (address_IMEM != prev_addr);
        loop_nxt    = '0;
        if (addr_same) begin
            loop_nxt = (&loop_cnt) ? loop_cnt : loop_cnt + LW'(1);
        end
        // Compare against the updated loop count so the halt fires on the LOOP_N-th repeat.
        loop_hit    = (LOOP_N != 0) && (loop_nxt == LOOP_LIM);
        halt_hit    = tohost_hit || (Instruction == HALT_WORD) || loop_hit;
        timeout_hit = (TIMEOUT != 0) && (cycle_count == TO_LAST);
        cycle_nxt   = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
        fetch_nxt   = (addr_diff && !(&fetch_count)) ? fetch_count + CNT_W'(1) : fetch_count;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_IDLE;
            core_RSTn   <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            fetch_count <= '0;
            halt_pc     <= '0;
            phase_cnt   <= '0;
            prev_addr   <= '0;
            loop_cnt    <= '0;
            first_run   <= 1'b0;
`ifdef TOHOST_EN
            exit_code   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_HALTED, S_TIMED_OUT: begin
                    if (start) begin
                        state       <= S_CORE_RST;
                        core_RSTn   <= 1'b0;
                        running     <= 1'b0;
                        done        <= 1'b0;
                        timeout     <= 1'b0;
                        cycle_count <= '0;
                        fetch_count <= '0;
                        halt_pc     <= '0;
                        phase_cnt   <= '0;
`ifdef TOHOST_EN
                        exit_code   <= '0;
`endif
                    end
                end
                S_CORE_RST: begin
                    if (phase_cnt == RST_LAST) begin
                        phase_cnt <= '0;
                        core_RSTn <= 1'b1;
                        if (SETTLE == 0) begin
                            state     <= S_RUN;
                            running   <= 1'b1;
                            first_run <= 1'b1;
                            loop_cnt  <= '0;
                        end else begin
                            state <= S_SETTLE;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                S_SETTLE: begin
                    if (phase_cnt == SET_LAST) begin
                        phase_cnt <= '0;
                        state     <= S_RUN;
                        running   <= 1'b1;
                        first_run <= 1'b1;
                        loop_cnt  <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                S_RUN: begin
                    // The stopping cycle itself is still counted; counters freeze afterwards.
                    prev_addr   <= address_IMEM;
                    first_run   <= 1'b0;
                    loop_cnt    <= loop_nxt;
                    cycle_count <= cycle_nxt;
                    fetch_count <= fetch_nxt;
                    if (halt_hit) begin
                        state   <= S_HALTED;
                        running <= 1'b0;
                        done    <= 1'b1;
                        halt_pc <= address_IMEM;
`ifdef TOHOST_EN
                        if (tohost_hit) begin
                            exit_code <= write_data_DMEM;
                        end
`endif
                    end else if (timeout_hit) begin
                        state   <= S_TIMED_OUT;
                        running <= 1'b0;
                        timeout <= 1'b1;
                        halt_pc <= address_IMEM;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a per-cycle reference model and literal spot checks.
// Latency: inputs driven on falling edges, outputs compared on falling edges.
// Backpressure: not applicable.
module tb_cpu_run_ctrl;

    localparam int          RSTC  = 2;
    localparam int          SETL  = 1;
    localparam int          LOOPN = 4;
    localparam int          TOUT  = 50;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [31:0] Instruction;
    logic [9:0]  address_IMEM;
    logic        MemWrite;
    logic [9:0]  address_DMEM;
    logic [31:0] write_data_DMEM;
    logic        core_RSTn;
    logic        running;
    logic        done;
    logic        timeout;
    logic [31:0] cycle_count;
    logic [31:0] fetch_count;
    logic [9:0]  halt_pc;
    logic [31:0] exit_code;

    int total_n = 0;
    int bad_n   = 0;

    cpu_run_ctrl #(
        .ADDR_W    (10),
        .HALT_WORD (32'h0000_0000),
        .RST_CYCLES(RSTC),
        .SETTLE    (SETL),
        .LOOP_N    (LOOPN),
        .TIMEOUT   (TOUT),
        .CNT_W     (32)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .start          (start),
        .Instruction    (Instruction),
        .address_IMEM   (address_IMEM),
        .MemWrite       (MemWrite),
        .address_DMEM   (address_DMEM),
        .write_data_DMEM(write_data_DMEM),
        .core_RSTn      (core_RSTn),
        .running        (running),
        .done           (done),
        .timeout        (timeout),
        .cycle_count    (cycle_count),
        .fetch_count    (fetch_count),
        .halt_pc        (halt_pc),
        .exit_code      (exit_code)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_n++;
        if (act !== exp) begin
            bad_n++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 start sequence, 2 run, 3 halted, 4 timed out.
    // During a run it keeps the list of sampled fetch addresses; counts derive from that list.
    int          m_ph  = 0;
    int          m_age = 0;
    logic [9:0]  m_q[$];
    logic [9:0]  m_hpc  = '0;
    logic [31:0] m_exit = '0;
    bit          m_th;

    function automatic int fetches();
        int n = 0;
        for (int i = 1; i < m_q.size(); i++) if (m_q[i] != m_q[i-1]) n++;
        return n;
    endfunction

    function automatic int trail_eq();
        int n = 0;
        for (int i = m_q.size() - 1; i > 0; i--) begin
            if (m_q[i] != m_q[i-1]) break;
            n++;
        end
        return n;
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            m_ph = 0; m_age = 0; m_q.delete(); m_hpc = '0; m_exit = '0;
        end else begin
            case (m_ph)
                0, 3, 4: if (start) begin
                    m_ph = 1; m_age = 1; m_q.delete(); m_hpc = '0; m_exit = '0;
                end
                1: begin
                    m_age++;
                    if (m_age > RSTC + SETL) m_ph = 2;
                end
                2: begin
                    m_q.push_back(address_IMEM);
`ifdef TOHOST_EN
                    m_th = MemWrite && (address_DMEM == 10'h3FC);
`else
                    m_th = 1'b0;
`endif
                    if (m_th || Instruction == 32'h0 || trail_eq() >= LOOPN) begin
                        m_ph = 3; m_hpc = address_IMEM;
                        if (m_th) m_exit = write_data_DMEM;
                    end else if (m_q.size() == TOUT) begin
                        m_ph = 4; m_hpc = address_IMEM;
                    end
                end
                default: m_ph = 0;
            endcase
        end
    end

    always @(negedge CLK) begin
        chk("cyc_core_RSTn", core_RSTn, (m_ph == 1) ? (m_age > RSTC) : (m_ph != 0));
        chk("cyc_running", running, m_ph == 2);
        chk("cyc_done", done, m_ph == 3);
        chk("cyc_timeout", timeout, m_ph == 4);
        chk("cyc_cycle_count", cycle_count, m_q.size());
        chk("cyc_fetch_count", fetch_count, fetches());
        chk("cyc_halt_pc", halt_pc, m_hpc);
        chk("cyc_exit_code", exit_code, m_exit);
    end

    task automatic run_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk("seq_c1_rstn", core_RSTn, 0);
        @(negedge CLK);
        chk("seq_c2_rstn", core_RSTn, 0);
        @(negedge CLK);
        chk("seq_c3_rstn", core_RSTn, 1);
        chk("seq_c3_running", running, 0);
        @(negedge CLK);
        chk("seq_c4_running", running, 1);
    endtask

    task automatic drive(input logic [9:0] addr, input logic [31:0] instr);
        address_IMEM = addr;
        Instruction  = instr;
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; Instruction = NOP; address_IMEM = '0;
        MemWrite = 1'b0; address_DMEM = '0; write_data_DMEM = '0;
        repeat (3) @(negedge CLK);
        chk("rst_core_RSTn", core_RSTn, 0);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_halt_pc", halt_pc, 0);
        RST = 1'b0;
        @(negedge CLK);
        chk("idle_core_RSTn", core_RSTn, 0);

        // PC 0,4,...,0x24 then halt word at 0x28.
        run_start();
        for (int i = 0; i < 11; i++) drive(10'(i * 4), (i == 10) ? 32'h0 : NOP);
        chk("halt_done", done, 1);
        chk("halt_pc_28", halt_pc, 10'h28);
        chk("halt_cycles", cycle_count, 11);
        chk("halt_fetches", fetch_count, 10);
        repeat (3) drive(10'h3C0, NOP);
        chk("halt_frozen_cycles", cycle_count, 11);

        // PC stuck at 0x10: halts on the fourth repeat, i.e. the fifth RUN cycle.
        run_start();
        for (int i = 0; i < 5; i++) drive(10'h10, NOP);
        chk("loop_done", done, 1);
        chk("loop_halt_pc", halt_pc, 10'h10);
        chk("loop_cycles", cycle_count, 5);
        chk("loop_fetches", fetch_count, 0);

        // Free-running PC with no halt: timeout after 50 RUN cycles; start mid-run ignored.
        run_start();
        for (int i = 0; i < 50; i++) begin
            start = (i == 20);
`ifndef TOHOST_EN
            MemWrite = (i == 10); address_DMEM = 10'h3FC; write_data_DMEM = 32'h5;
`endif
            drive(10'(i * 4), NOP);
        end
        start = 1'b0; MemWrite = 1'b0;
        chk("to_timeout", timeout, 1);
        chk("to_done", done, 0);
        chk("to_cycles", cycle_count, 50);
        chk("to_halt_pc", halt_pc, 10'hC4);
        chk("to_exit_code", exit_code, 0);

        // Halt word on the 50th RUN cycle beats the timeout.
        run_start();
        for (int i = 0; i < 50; i++) drive(10'(i * 4), (i == 49) ? 32'h0 : NOP);
        chk("edge_done", done, 1);
        chk("edge_timeout", timeout, 0);
        chk("edge_cycles", cycle_count, 50);

`ifdef TOHOST_EN
        run_start();
        for (int i = 0; i < 3; i++) drive(10'(i * 4), NOP);
        MemWrite = 1'b1; address_DMEM = 10'h3FC; write_data_DMEM = 32'h1;
        drive(10'h00C, 32'h0);
        MemWrite = 1'b0;
        chk("tohost_done", done, 1);
        chk("tohost_exit", exit_code, 1);
`endif

        // RST mid-run, with start asserted alongside it: RST wins.
        run_start();
        for (int i = 0; i < 5; i++) drive(10'(i * 4), NOP);
        RST = 1'b1; start = 1'b1;
        @(negedge CLK);
        chk("midrst_core_RSTn", core_RSTn, 0);
        chk("midrst_running", running, 0);
        chk("midrst_cycles", cycle_count, 0);
        @(negedge CLK);
        RST = 1'b0; start = 1'b0;
        repeat (2) @(negedge CLK);
        chk("midrst_idle_rstn", core_RSTn, 0);
        chk("midrst_idle_running", running, 0);

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
